arbitro_prioridad: RTL

Eight-requester bus arbiter that shares one resource among eight masters. It uses the same priority-encoding rule as the team's 8-to-3 encoder: a one-hot request vector becomes a winner index plus a "grant valid" flag. The block adds registered grants, ownership hold until release, a hold-time watchdog and optional round-robin fairness. It sits between the requesting masters and the shared datapath mux, and drives that mux's select with `gnt_id`.

---
 rtl/arbitro_prioridad_if.sv | 20 ++
 rtl/arbitro_prioridad.sv | 109 ++++++++++
 2 files changed

// File: rtl/arbitro_prioridad_if.sv
// Request/grant bundle between the masters and arbitro_prioridad.
// master: requesting side; slave: arbiter side.
interface arbitro_prioridad_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       valid;
    logic       tout;

    modport master (
        output req, done,
        input  gnt, gnt_id, valid, tout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, valid, tout
    );
endinterface

// File: rtl/arbitro_prioridad.sv
// Eight-master bus arbiter: registered one-hot grant, hold until release,
// hold-time watchdog. ARBITRO_PRIORIDAD_RR_EN selects round-robin fairness.
module arbitro_prioridad #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    arbitro_prioridad_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Watchdog fires on the edge where the owner has held MAX_HOLD cycles.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam bit         WD_EN     = (MAX_HOLD != 0);

    state_t     state_q;
    logic [7:0] gnt_q;
    logic [2:0] gnt_id_q;
    logic       valid_q;
    logic       tout_q;
    logic [7:0] cnt_q;

    logic [2:0] win_id_d;
    logic [7:0] win_oh_d;
    logic       release_d;
    logic       wd_hit_d;

`ifdef ARBITRO_PRIORIDAD_RR_EN
    logic [2:0] last_q;

    // Search last-1 downward; the previous owner (i=8) is visited last.
    always_comb begin
        win_id_d = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            if (bus.req[last_q - 3'(i)]) win_id_d = last_q - 3'(i);
        end
    end
`else
    // Fixed priority: the highest set request index wins.
    always_comb begin
        win_id_d = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.req[i]) win_id_d = 3'(i);
        end
    end
`endif

    assign win_oh_d  = 8'd1 << win_id_d;
    assign release_d = bus.done | ~bus.req[gnt_id_q];
    assign wd_hit_d  = WD_EN && (cnt_q == HOLD_LAST);

    // Grant FSM: all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 8'd0;
            gnt_id_q <= 3'd0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
            cnt_q    <= 8'd0;
`ifdef ARBITRO_PRIORIDAD_RR_EN
            last_q   <= 3'd0;
`endif
        end else begin
            tout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q    <= win_oh_d;
                        gnt_id_q <= win_id_d;
                        valid_q  <= 1'b1;
                        cnt_q    <= 8'd0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_d) begin
                        gnt_q   <= 8'd0;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
`ifdef ARBITRO_PRIORIDAD_RR_EN
                        last_q  <= gnt_id_q;
`endif
                    end else if (wd_hit_d) begin
                        gnt_q   <= 8'd0;
                        valid_q <= 1'b0;
                        tout_q  <= 1'b1;
                        state_q <= IDLE;
`ifdef ARBITRO_PRIORIDAD_RR_EN
                        last_q  <= gnt_id_q;
`endif
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.valid  = valid_q;
    assign bus.tout   = tout_q;

endmodule
